// File: rtl/fp_alu_sequencer.sv
// ============================================================================
// Module   : fp_alu_sequencer
// Purpose  : Sequences single commands into an external combinational FP ALU.
//            A command is accepted in IDLE, its operands are registered onto
//            the ALU inputs, the ALU is given SETTLE_CYCLES edges to settle,
//            and the result is captured and offered on a valid/ready response
//            port together with NaN / infinity / invalid-opcode flags.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            cmd_valid/cmd_ready - command handshake
//            cmd_a, cmd_b        - IEEE-754 single operands
//            cmd_opcode          - 00 add, 01 mul, 10 div, 11 invalid
//            alu_a/alu_b/alu_opcode - registered drive to the external ALU
//            alu_result          - result returned by the external ALU
//            rsp_valid/rsp_ready - response handshake
//            rsp_result, rsp_opcode, rsp_invalid, rsp_nan, rsp_inf
//                                - captured response and its flags
//            op_count            - completed response handshakes (wraps)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_alu_sequencer #(
    // Settle time of the external ALU in clock edges; legal range 1..15.
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [1:0]  cmd_opcode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_opcode,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [1:0]  rsp_opcode,
    output logic        rsp_invalid,
    output logic        rsp_nan,
    output logic        rsp_inf,
    output logic [15:0] op_count
);

    localparam logic [1:0] OP_INVALID = 2'b11;
    localparam logic [3:0] SETTLE_LD  = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q,       state_d;
    logic [3:0]  cnt_q,         cnt_d;
    logic [31:0] alu_a_q,       alu_a_d;
    logic [31:0] alu_b_q,       alu_b_d;
    logic [1:0]  alu_op_q,      alu_op_d;
    logic [31:0] rsp_result_q,  rsp_result_d;
    logic [1:0]  rsp_op_q,      rsp_op_d;
    logic        rsp_invalid_q, rsp_invalid_d;
    logic        rsp_nan_q,     rsp_nan_d;
    logic        rsp_inf_q,     rsp_inf_d;
    logic [15:0] op_count_q,    op_count_d;

    // Value that would be captured this cycle: an invalid opcode forces zero
    // regardless of what the ALU drives.
    logic        w_capt_inv;
    logic [31:0] w_capt_result;
    logic        w_capt_exp_ones;
    logic        w_capt_man_zero;

    always_comb begin
        w_capt_inv      = (alu_op_q == OP_INVALID);
        w_capt_result   = w_capt_inv ? 32'h0000_0000 : alu_result;
        w_capt_exp_ones = (w_capt_result[30:23] == 8'hFF);
        w_capt_man_zero = (w_capt_result[22:0] == 23'd0);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        rsp_result_d  = rsp_result_q;
        rsp_op_d      = rsp_op_q;
        rsp_invalid_d = rsp_invalid_q;
        rsp_nan_d     = rsp_nan_q;
        rsp_inf_d     = rsp_inf_q;
        op_count_d    = op_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d  = cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_opcode;
                    cnt_d    = SETTLE_LD;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // A counter of 0 cannot occur for a legal parameter; it is
                // treated like 1 so the FSM can never stall in WAIT.
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d         = 4'd0;
                    rsp_result_d  = w_capt_result;
                    rsp_op_d      = alu_op_q;
                    rsp_invalid_d = w_capt_inv;
                    rsp_nan_d     = w_capt_exp_ones && !w_capt_man_zero;
                    rsp_inf_d     = w_capt_exp_ones &&  w_capt_man_zero;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            alu_op_q      <= 2'd0;
            rsp_result_q  <= 32'd0;
            rsp_op_q      <= 2'd0;
            rsp_invalid_q <= 1'b0;
            rsp_nan_q     <= 1'b0;
            rsp_inf_q     <= 1'b0;
            op_count_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rsp_result_q  <= rsp_result_d;
            rsp_op_q      <= rsp_op_d;
            rsp_invalid_q <= rsp_invalid_d;
            rsp_nan_q     <= rsp_nan_d;
            rsp_inf_q     <= rsp_inf_d;
            op_count_q    <= op_count_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_op_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_opcode  = rsp_op_q;
    assign rsp_invalid = rsp_invalid_q;
    assign rsp_nan     = rsp_nan_q;
    assign rsp_inf     = rsp_inf_q;
    assign op_count    = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_alu_sequencer.sv
// ============================================================================
// Module   : tb_fp_alu_sequencer
// Purpose  : Self-checking bench for fp_alu_sequencer. A driver issues
//            directed and random commands and pushes the expected response
//            into a scoreboard queue; an independent monitor compares every
//            presented response and the handshake count against it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_alu_sequencer;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [1:0]  cmd_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_opcode;
    logic        rsp_invalid;
    logic        rsp_nan;
    logic        rsp_inf;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    fp_alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_opcode  (cmd_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_opcode  (rsp_opcode),
        .rsp_invalid (rsp_invalid),
        .rsp_nan     (rsp_nan),
        .rsp_inf     (rsp_inf),
        .op_count    (op_count)
    );

    // Stand-in for the external ALU: an arbitrary deterministic function of
    // its inputs, or a forced value for directed special-value cases.
    logic        force_en;
    logic [31:0] force_val;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a ^ {b[15:0], b[31:16]};
            2'b10:   return a - b;
            default: return ~a;
        endcase
    endfunction

    always_comb alu_result = force_en ? force_val : alu_fn(alu_a, alu_b, alu_opcode);

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  op;
        logic        inv;
        logic        nan;
        logic        inf;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic        prev_valid = 1'b0;
    logic        rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference for a whole command: what the response must contain.
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] op, input logic fe,
                                       input logic [31:0] fv);
        exp_t e;
        e.op  = op;
        e.inv = (op == 2'b11);
        e.res = e.inv ? 32'd0 : (fe ? fv : alu_fn(a, b, op));
        e.nan = (e.res[30:23] == 8'hFF) && (e.res[22:0] != 23'd0);
        e.inf = (e.res[30:23] == 8'hFF) && (e.res[22:0] == 23'd0);
        e.acc = 0;
        return e;
    endfunction

    // Monitor: decoupled from the driver, compares whatever is presented.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            check("op_count", 64'(op_count), 64'(exp_cnt));
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 result=%h, expected no response", rsp_result);
                end else begin
                    mon_e = sb[0];
                    if (!prev_valid)
                        check("latency", 64'(cyc - mon_e.acc), 64'(SETTLE));
                    check("rsp_result", 64'(rsp_result), 64'(mon_e.res));
                    check("rsp_flags", 64'({rsp_opcode, rsp_invalid, rsp_nan, rsp_inf}),
                          64'({mon_e.op, mon_e.inv, mon_e.nan, mon_e.inf}));
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        exp_cnt = exp_cnt + 16'd1;
                    end
                end
            end
            prev_valid = rsp_valid;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic fe, input logic [31:0] fv, output int acc);
        int   k;
        exp_t e;
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (!cmd_ready && k < 200);
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got cmd_ready=0 expected 1 within 200 cycles");
        end
        force_en   = fe;
        force_val  = fv;
        cmd_a      = a;
        cmd_b      = b;
        cmd_opcode = op;
        cmd_valid  = 1'b1;
        e = ref_model(a, b, op, fe, fv);
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        e.acc = cyc;
        acc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || !cmd_ready) && k < 500) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (sb.size() != 0 || !cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d responses pending expected 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc0, acc1, k;
        logic [15:0] cnt_before;
        logic [31:0] ra, rb, fv;
        logic [1:0]  rop;
        logic        fe;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_a      = 32'd0;
        cmd_b      = 32'd0;
        cmd_opcode = 2'd0;
        rsp_ready  = 1'b0;
        force_en   = 1'b0;
        force_val  = 32'd0;

        // Reset for two cycles
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);

        // Add
        rsp_ready = 1'b1;
        issue(32'h40600000, 32'h40900000, 2'b00, 1'b1, 32'h41000000, acc0);
        check("add_alu_opcode", 64'(alu_opcode), 64'd0);
        check("add_alu_a", 64'(alu_a), 64'h40600000);
        check("add_alu_b", 64'(alu_b), 64'h40900000);
        drain();
        check("add_op_count", 64'(op_count), 64'd1);
        check("hold_alu_a", 64'(alu_a), 64'h40600000);

        // Back-to-back throughput with rsp_ready held high
        issue(32'h3F800000, 32'h40000000, 2'b01, 1'b0, 32'd0, acc0);
        issue(32'h40400000, 32'h40800000, 2'b10, 1'b0, 32'd0, acc1);
        check("throughput", 64'(acc1 - acc0), 64'(SETTLE + 2));
        drain();

        // Invalid opcode
        issue(32'h3FA00000, 32'hC0E9999A, 2'b11, 1'b0, 32'd0, acc0);
        drain();

        // Backpressure with a competing command and a changing ALU output
        rsp_ready = 1'b0;
        issue(32'h40000000, 32'h40400000, 2'b01, 1'b1, 32'h40C00000, acc0);
        k = 0;
        while (!rsp_valid && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        repeat (5) begin
            @(posedge clk);
            #2;
            cmd_valid  = 1'b1;
            cmd_a      = $urandom;
            cmd_b      = $urandom;
            cmd_opcode = 2'b00;
            force_val  = $urandom;
            #1;
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            check("bp_alu_a", 64'(alu_a), 64'h40000000);
            check("bp_rsp_result", 64'(rsp_result), 64'h40C00000);
        end
        @(posedge clk);
        #2;
        cmd_valid  = 1'b0;
        cnt_before = op_count;
        rsp_ready  = 1'b1;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        check("bp_count_inc", 64'(op_count), 64'(cnt_before + 16'd1));
        repeat (3) @(posedge clk);
        #2;
        check("bp_count_once", 64'(op_count), 64'(cnt_before + 16'd1));
        check("bp_alu_a_hold", 64'(alu_a), 64'h40000000);

        // Special values
        rsp_ready = 1'b1;
        issue(32'h00000000, 32'h00000000, 2'b10, 1'b1, 32'h7FC00000, acc0);
        issue(32'hBF800000, 32'h7F800000, 2'b01, 1'b1, 32'hFF800000, acc0);
        issue(32'h7F800000, 32'h3F800000, 2'b00, 1'b1, 32'h7F800001, acc0);
        issue(32'h7F800000, 32'h3F800000, 2'b00, 1'b1, 32'h7F7FFFFF, acc0);
        drain();

        // Reset one edge after acceptance discards the command
        rsp_ready = 1'b1;
        issue(32'h41200000, 32'h40A00000, 2'b00, 1'b0, 32'd0, acc0);
        rst = 1'b1;
        sb.delete();
        exp_cnt = 16'd0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (SETTLE + 3) @(posedge clk);
        #2;
        check("midrst_op_count", 64'(op_count), 64'd0);

        // Random traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) ra[30:23] = 8'hFF;
            if ($urandom_range(0, 3) == 0) rb[30:23] = 8'hFF;
            rop = 2'($urandom_range(0, 3));
            fe  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       fv = 32'h7FC00000;
                1:       fv = 32'hFF800000;
                2:       fv = 32'h7F800000;
                default: fv = $urandom;
            endcase
            issue(ra, rb, rop, fe, fv, acc0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        rand_rdy = 1'b0;
        #3;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
